// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM encoding and
// default sizing.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT_RUN = 2'b01,
    DIV_RUN  = 2'b10,
    DONE     = 2'b11
  } state_e;

  localparam int WIDTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 40;
  localparam int CNT_W_DEF   = 6;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Request/response and datapath-facing signals of the multiply/divide
// sequencer; the sequencer uses the slave modport.
interface multdiv_sequencer_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mult_start;
  logic             div_start;
  logic             mult_done;
  logic [WIDTH-1:0] mult_result;
  logic             mult_ovf;
  logic             div_done;
  logic [WIDTH-1:0] div_result;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  mult_done, mult_result, mult_ovf, div_done, div_result,
    output op_a, op_b, mult_start, div_start,
    output data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output mult_done, mult_result, mult_ovf, div_done, div_result,
    input  op_a, op_b, mult_start, div_start,
    input  data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_cycle_counter.sv
// Clearable, enabled, saturating cycle counter used as the run-state watchdog.
module multdiv_cycle_counter #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic reach,
  output logic at_limit
);
  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LIM)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // reach: the increment taken at this edge lands exactly on the limit.
  assign reach    = en && !clear && (count_q == LIM_M1);
  assign at_limit = (count_q == LIM);
endmodule

// File: rtl/multdiv_sequencer.sv
// Shares one multiplier and one divider behind a single request port:
// latches operands, starts the chosen unit, waits for done or watchdog.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic                clock,
  input logic                reset,
  multdiv_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             mult_start_q, mult_start_d;
  logic             div_start_q, div_start_d;
  logic             cnt_clear, cnt_en, cnt_reach, cnt_at_limit, watchdog;

  assign cnt_en   = (state_q == MULT_RUN) || (state_q == DIV_RUN);
  assign watchdog = cnt_reach || cnt_at_limit;

  multdiv_cycle_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .reach    (cnt_reach),
    .at_limit (cnt_at_limit)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    exc_d        = exc_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    cnt_clear    = 1'b0;

    // A new request always wins over whatever is in flight; multiply beats divide.
    if (bus.ctrl_MULT) begin
      state_d      = MULT_RUN;
      op_a_d       = bus.data_operandA;
      op_b_d       = bus.data_operandB;
      result_d     = '0;
      exc_d        = 1'b0;
      mult_start_d = 1'b1;
      cnt_clear    = 1'b1;
    end else if (bus.ctrl_DIV) begin
      result_d  = '0;
      cnt_clear = 1'b1;
      if (bus.data_operandB != '0) begin
        state_d     = DIV_RUN;
        op_a_d      = bus.data_operandA;
        op_b_d      = bus.data_operandB;
        exc_d       = 1'b0;
        div_start_d = 1'b1;
      end else begin
        state_d = DONE;
        exc_d   = 1'b1;
      end
    end else begin
      case (state_q)
        MULT_RUN: begin
          // A done seen during the start cycle belongs to an earlier run.
          if (bus.mult_done && !mult_start_q) begin
            state_d  = DONE;
            result_d = bus.mult_result;
            exc_d    = bus.mult_ovf;
          end else if (watchdog) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end
        end
        DIV_RUN: begin
          if (bus.div_done && !div_start_q) begin
            state_d  = DONE;
            result_d = bus.div_result;
            exc_d    = 1'b0;
          end else if (watchdog) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == MULT_RUN) || (state_d == DIV_RUN);
    rdy_d  = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
    end
  end

  assign bus.op_a           = op_a_q;
  assign bus.op_b           = op_b_q;
  assign bus.mult_start     = mult_start_q;
  assign bus.div_start      = div_start_q;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: hand-timed unit done responses and
// hand-computed expected results.
module tb_multdiv_sequencer;
  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   n_mstart, n_dstart, n_busy, n_rdy;

  multdiv_sequencer_if #(.WIDTH(32)) bus ();

  multdiv_sequencer #(
    .WIDTH   (32),
    .TIMEOUT (40),
    .CNT_W   (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_tally();
    n_mstart = 0;
    n_dstart = 0;
    n_busy   = 0;
    n_rdy    = 0;
  endtask

  // Advance to the next falling edge and tally the pulse-type outputs.
  task automatic step();
    @(negedge clock);
    if (bus.mult_start)     n_mstart++;
    if (bus.div_start)      n_dstart++;
    if (bus.busy)           n_busy++;
    if (bus.data_resultRDY) n_rdy++;
  endtask

  task automatic request(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    step();
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    errors = 0;
    checks = 0;
    clr_tally();
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.mult_done     = 1'b0;
    bus.mult_result   = '0;
    bus.mult_ovf      = 1'b0;
    bus.div_done      = 1'b0;
    bus.div_result    = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_opa", bus.op_a, 32'd0);
    reset = 1'b0;
    $display("reset: busy=%0d rdy=%0d result=%0h", bus.busy, bus.data_resultRDY, bus.data_result);

    // 1: multiply 7 * -3, done sampled at the end of the 16th run cycle
    clr_tally();
    request(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul_start_c1", 32'(bus.mult_start), 32'd1);
    check("mul_opa", bus.op_a, 32'd7);
    check("mul_opb", bus.op_b, 32'hFFFF_FFFD);
    repeat (15) step();
    bus.mult_done   = 1'b1;
    bus.mult_result = 32'hFFFF_FFEB;
    step();
    bus.mult_done = 1'b0;
    check("mul_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("mul_result", bus.data_result, 32'hFFFF_FFEB);
    check("mul_exc", 32'(bus.data_exception), 32'd0);
    step();
    check("mul_rdy_drop", 32'(bus.data_resultRDY), 32'd0);
    check("mul_result_hold", bus.data_result, 32'hFFFF_FFEB);
    check("mul_start_cnt", 32'(n_mstart), 32'd1);
    check("mul_busy_cnt", 32'(n_busy), 32'd16);
    check("mul_rdy_cnt", 32'(n_rdy), 32'd1);
    $display("mult 7*-3: result=%0h exc=%0d busy_cycles=%0d", bus.data_result, bus.data_exception, n_busy);

    // 2: divide 100 / 7, done after 33 cycles
    clr_tally();
    request(1'b0, 1'b1, 32'd100, 32'd7);
    check("div_start_c1", 32'(bus.div_start), 32'd1);
    check("div_result_cleared", bus.data_result, 32'd0);
    repeat (32) step();
    bus.div_done   = 1'b1;
    bus.div_result = 32'd14;
    step();
    bus.div_done = 1'b0;
    check("div_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("div_result", bus.data_result, 32'd14);
    check("div_exc", 32'(bus.data_exception), 32'd0);
    check("div_start_cnt", 32'(n_dstart), 32'd1);
    check("div_mstart_cnt", 32'(n_mstart), 32'd0);
    check("div_busy_cnt", 32'(n_busy), 32'd33);
    $display("div 100/7: result=%0d exc=%0d", bus.data_result, bus.data_exception);

    // 3: divide by zero completes the cycle after the request
    step();
    clr_tally();
    request(1'b0, 1'b1, 32'd5, 32'd0);
    check("dz_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("dz_result", bus.data_result, 32'd0);
    check("dz_exc", 32'(bus.data_exception), 32'd1);
    check("dz_busy", 32'(bus.busy), 32'd0);
    step();
    check("dz_rdy_drop", 32'(bus.data_resultRDY), 32'd0);
    check("dz_exc_hold", 32'(bus.data_exception), 32'd1);
    check("dz_start_cnt", 32'(n_dstart), 32'd0);
    $display("div 5/0: result=%0d exc=%0d", bus.data_result, bus.data_exception);

    // 4: multiply aborted by a divide; a stale mult_done must be ignored
    clr_tally();
    request(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (3) step();
    request(1'b0, 1'b1, 32'd9, 32'd3);
    check("ab_div_start", 32'(bus.div_start), 32'd1);
    check("ab_opa", bus.op_a, 32'd9);
    bus.mult_done   = 1'b1;
    bus.mult_result = 32'd12;
    step();
    bus.mult_done = 1'b0;
    check("ab_stale_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("ab_stale_busy", 32'(bus.busy), 32'd1);
    repeat (8) step();
    bus.div_done   = 1'b1;
    bus.div_result = 32'd3;
    step();
    bus.div_done = 1'b0;
    check("ab_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("ab_result", bus.data_result, 32'd3);
    check("ab_rdy_cnt", 32'(n_rdy), 32'd1);
    check("ab_start_cnts", 32'({n_mstart[15:0], n_dstart[15:0]}), 32'h0001_0001);
    $display("abort mult(3,4)->div(9,3): result=%0d rdy_pulses=%0d", bus.data_result, n_rdy);

    // 5: simultaneous request, done seen only in the start cycle, then watchdog
    step();
    clr_tally();
    request(1'b1, 1'b1, 32'd2, 32'd2);
    check("sim_mstart", 32'(bus.mult_start), 32'd1);
    check("sim_dstart", 32'(bus.div_start), 32'd0);
    bus.mult_done   = 1'b1;
    bus.mult_result = 32'd4;
    step();
    bus.mult_done = 1'b0;
    check("sim_startcycle_done_ignored", 32'(bus.data_resultRDY), 32'd0);
    repeat (38) step();
    check("to_not_yet", 32'(bus.data_resultRDY), 32'd0);
    step();
    check("to_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("to_result", bus.data_result, 32'd0);
    check("to_exc", 32'(bus.data_exception), 32'd1);
    check("to_busy_cnt", 32'(n_busy), 32'd40);
    check("to_dstart_cnt", 32'(n_dstart), 32'd0);
    $display("timeout: result=%0d exc=%0d busy_cycles=%0d", bus.data_result, bus.data_exception, n_busy);

    // 6: asynchronous reset in the middle of a divide
    step();
    clr_tally();
    request(1'b0, 1'b1, 32'd50, 32'd5);
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_opa", bus.op_a, 32'd0);
    check("ar_exc", 32'(bus.data_exception), 32'd0);
    check("ar_rdy", 32'(bus.data_resultRDY), 32'd0);
    @(negedge clock);
    reset         = 1'b0;
    bus.div_done   = 1'b1;
    bus.div_result = 32'd10;
    clr_tally();
    step();
    bus.div_done = 1'b0;
    step();
    check("ar_stray_rdy_cnt", 32'(n_rdy), 32'd0);
    request(1'b1, 1'b0, 32'd6, 32'd6);
    repeat (4) step();
    bus.mult_done   = 1'b1;
    bus.mult_result = 32'd36;
    step();
    bus.mult_done = 1'b0;
    check("ar_mul_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("ar_mul_result", bus.data_result, 32'd36);
    $display("reset then mult 6*6: result=%0d exc=%0d", bus.data_result, bus.data_exception);

    // 7: multiplier overflow propagates to the exception flag
    step();
    request(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    repeat (2) step();
    bus.mult_done   = 1'b1;
    bus.mult_result = 32'd0;
    bus.mult_ovf    = 1'b1;
    step();
    bus.mult_done = 1'b0;
    bus.mult_ovf  = 1'b0;
    check("ovf_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("ovf_exc", 32'(bus.data_exception), 32'd1);
    $display("mult overflow: result=%0h exc=%0d", bus.data_result, bus.data_exception);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
